seq_magnitude_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator. It compares two WIDTH-bit operands one DIGIT-bit slice per clock, starting from the most significant slice, and supports unsigned or two's-complement mode per request. It produces registered Equal/Bigger/Lower flags with a start/busy/done handshake. It is the clocked, width-generic successor to the team's 4-bit combinational comparator, intended for wide-operand datapaths where a single-cycle compare would limit timing.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_slice.sv | 14 +
 rtl/seq_magnitude_comparator.sv | 129 ++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cmp_state_e;

    typedef logic [1:0] cmp_res_t;

    localparam cmp_res_t CMP_EQ = 2'd0;
    localparam cmp_res_t CMP_GT = 2'd1;
    localparam cmp_res_t CMP_LT = 2'd2;

    function automatic int cmp_ndig(input int width, input int digit);
        return width / digit;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// Combinational unsigned compare of one DIGIT-wide operand slice.
module cmp_slice #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, one DIGIT slice per clock.
// Optional SEQ_CMP_EARLY_EXIT_EN: leave RUN on the first differing slice.
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             Equal,
    output logic             Bigger,
    output logic             Lower
);

    localparam int NDIG = cmp_ndig(WIDTH, DIGIT);
    localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    cmp_state_e       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    cmp_res_t         r_res;
    logic             r_busy;
    logic             r_done;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;

    logic [NDIG-1:0][DIGIT-1:0] w_a_dig;
    logic [NDIG-1:0][DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0]           w_sa;
    logic [DIGIT-1:0]           w_sb;
    logic                       w_gt;
    logic                       w_lt;
    logic                       w_last;
    cmp_res_t                   w_res_next;

    assign w_a_dig = r_a;
    assign w_b_dig = r_b;
    assign w_sa    = w_a_dig[r_idx];
    assign w_sb    = w_b_dig[r_idx];

    cmp_slice #(.DIGIT(DIGIT)) u_slice (
        .a  (w_sa),
        .b  (w_sb),
        .gt (w_gt),
        .lt (w_lt)
    );

    // Sticky: the first differing slice (most significant) decides the order.
    always_comb begin
        w_res_next = r_res;
        if (r_res == CMP_EQ) begin
            if (w_gt)
                w_res_next = CMP_GT;
            else if (w_lt)
                w_res_next = CMP_LT;
        end
    end

`ifdef SEQ_CMP_EARLY_EXIT_EN
    assign w_last = (r_idx == '0) || (w_res_next != CMP_EQ);
`else
    assign w_last = (r_idx == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_res   <= CMP_EQ;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        // Flipping both MSBs maps two's-complement order onto unsigned order.
                        r_a     <= A ^ (sgn ? MSB_MASK : '0);
                        r_b     <= B ^ (sgn ? MSB_MASK : '0);
                        r_idx   <= IDXW'(NDIG - 1);
                        r_res   <= CMP_EQ;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res <= w_res_next;
                    if (w_last) begin
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                        r_eq    <= (w_res_next == CMP_EQ);
                        r_gt    <= (w_res_next == CMP_GT);
                        r_lt    <= (w_res_next == CMP_LT);
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign Equal  = r_eq;
    assign Bigger = r_gt;
    assign Lower  = r_lt;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed self-checking bench for seq_magnitude_comparator (WIDTH=16, DIGIT=4).
module tb_seq_magnitude_comparator;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int NDIG  = WIDTH / DIGIT;
`ifdef SEQ_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_GT = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             Equal;
    logic             Bigger;
    logic             Lower;

    int n_tests = 0;
    int n_fail  = 0;

    seq_magnitude_comparator #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sgn    (sgn),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Equal  (Equal),
        .Bigger (Bigger),
        .Lower  (Lower)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One compare; inputs are scrambled right after E0 to prove they are latched.
    task automatic run_cmp(input string tag, input logic s, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [2:0] exp_f, input int early_lat);
        int lat;
        int exp_lat;
        exp_lat = EARLY ? early_lat : NDIG;
        lat = 0;
        @(negedge clk);
        sgn = s; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = WIDTH'($urandom); B = WIDTH'($urandom); sgn = 1'($urandom);
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_flags"}, 32'({Equal, Bigger, Lower}), 32'(exp_f));
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 32'({done, busy}), 32'd0);
        chk({tag, "_flags_hold"}, 32'({Equal, Bigger, Lower}), 32'(exp_f));
    endtask

    initial begin
        int pulses;
        int first;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'({busy, done, Equal, Bigger, Lower}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_cmp("u_lt",     1'b0, 16'h0034, 16'h0040, F_LT, 3);
        run_cmp("msb_gt",   1'b0, 16'h5000, 16'h4FFF, F_GT, 1);
        run_cmp("eq",       1'b0, 16'h0606, 16'h0606, F_EQ, 4);
        run_cmp("s_lt",     1'b1, 16'hFFFF, 16'h0001, F_LT, 1);
        run_cmp("u_gt",     1'b0, 16'hFFFF, 16'h0001, F_GT, 1);
        run_cmp("s_min",    1'b1, 16'h8000, 16'h7FFF, F_LT, 1);
        run_cmp("s_lsb_lt", 1'b1, 16'hFFFE, 16'hFFFF, F_LT, 4);
        run_cmp("s_eq",     1'b1, 16'h8000, 16'h8000, F_EQ, 4);
        run_cmp("u_mid_gt", 1'b0, 16'h1A00, 16'h1900, F_GT, 2);

        // start held high, operands churned every cycle during RUN.
        @(negedge clk);
        sgn = 1'b0; A = 16'h1234; B = 16'h1235; start = 1'b1;
        @(posedge clk); #1;
        pulses = 0; first = 0;
        for (int k = 1; k <= NDIG; k++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom); sgn = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        chk("hs1_pulses", pulses, 1);
        chk("hs1_lat", first, NDIG);
        chk("hs1_flags", 32'({Equal, Bigger, Lower}), 32'(F_LT));
        sgn = 1'b0; A = 16'h0001; B = 16'h0000;
        @(posedge clk); #1;
        chk("hs_idle_gap", 32'({busy, done}), 32'd0);
        @(posedge clk); #1;
        chk("hs2_busy", 32'(busy), 32'd1);
        pulses = 0; first = 0;
        for (int k = 1; k <= NDIG; k++) begin
            A = WIDTH'($urandom); B = WIDTH'($urandom); sgn = 1'($urandom);
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        start = 1'b0;
        chk("hs2_pulses", pulses, 1);
        chk("hs2_lat", first, NDIG);
        chk("hs2_flags", 32'({Equal, Bigger, Lower}), 32'(F_GT));
        @(posedge clk); #1;
        chk("hs2_done_fall", 32'({busy, done}), 32'd0);

        // Reset asserted while idx=2 (after E1).
        @(negedge clk);
        sgn = 1'b0; A = 16'h0034; B = 16'h0040; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async", 32'({busy, done, Equal, Bigger, Lower}), 32'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
            if (k == 2) rst = 1'b0;
        end
        chk("rst_no_done", pulses, 0);
        chk("rst_idle", 32'({busy, Equal, Bigger, Lower}), 32'd0);
        run_cmp("post_rst", 1'b0, 16'h0034, 16'h0040, F_LT, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
